// File: rtl/csidh_pkg.sv
// Shared constants and types for the CSIDH-512 field arithmetic port.
//   P      : field modulus (CSIDH-512 prime)
//   P_INV  : (-p)^-1 mod 2^512; only the low word (n0') feeds the multiplier
//   FP1    : 2^512 mod p, the Montgomery representation of 1
//   OP_*   : opcode encodings on the shared port
//   state_t: responder FSM states
package csidh_pkg;

  localparam logic [511:0] P =
    512'h65b48e8f740f89bf_fc8ab0d15e3e4c4a_b42d083aedc88c42_5afbfcc69322c9cd_a7aac6c567f35507_516730cc1f0b4f25_c2721bf457aca835_1b81b90533c6c87b;

  // Newton iteration x <- x(2 - p x) doubles the correct low bits each step;
  // an odd p is its own inverse mod 8, so 9 steps cover 512 bits.
  function automatic logic [511:0] calc_neg_p_inv();
    logic [511:0] x;
    x = P;
    for (int k = 0; k < 9; k++) x = x * (512'd2 - P * x);
    return -x;
  endfunction

  localparam logic [511:0] P_INV  = calc_neg_p_inv();
  localparam logic [512:0] R_WIDE = {1'b1, 512'b0};
  localparam logic [512:0] FP1_W  = R_WIDE % {1'b0, P};
  localparam logic [511:0] FP1    = FP1_W[511:0];

  localparam logic [1:0] OP_MUL = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;

  typedef enum logic [3:0] {
    ST_IDLE, ST_ADDSUB, ST_MAC, ST_MAC_TOP, ST_RED_M, ST_RED, ST_RED_TOP,
    ST_FINAL, ST_DONE
  } state_t;

endpackage

// File: rtl/word_mac.sv
// Word multiply-accumulate: {hi, lo} = x*y + t + c.
//   x, y, t, c : W-bit inputs
//   hi, lo     : W-bit halves of the 2W-bit result (never overflows 2W bits)
module word_mac #(
  parameter int W = 32
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] t,
  input  logic [W-1:0] c,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);
  logic [2*W-1:0] xe, ye, te, ce;

  assign xe = {{W{1'b0}}, x};
  assign ye = {{W{1'b0}}, y};
  assign te = {{W{1'b0}}, t};
  assign ce = {{W{1'b0}}, c};
  assign {hi, lo} = xe * ye + te + ce;
endmodule

// File: rtl/fp_arith_unit.sv
// Field arithmetic responder: Montgomery multiply (word-serial CIOS), modular
// add and modular subtract mod p, with operand-independent latency.
//   clk, rst      : clock, synchronous active-high reset
//   A, B, op      : operands (< p) and opcode, captured on the request cycle
//   rst_mul       : 1 = abort/idle, 0 = start and hold request
//   mul, done_mul : registered result and valid, held until rst_mul rises
module fp_arith_unit
  import csidh_pkg::*;
#(
  parameter int           N         = 512,
  parameter int           word_size = 32,
  parameter logic [N-1:0] p         = P,
  parameter logic [N-1:0] p_inv     = P_INV
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [1:0]   op,
  input  logic         rst_mul,
  output logic [N-1:0] mul,
  output logic         done_mul
);
  localparam int W  = word_size;
  localparam int S  = N / word_size;
  localparam int CW = $clog2(S);
  localparam logic [CW-1:0] LAST = CW'(S - 1);

  state_t              state;
  logic [N-1:0]        a_q, b_q;
  logic [1:0]          op_q;
  logic [S+1:0][W-1:0] t;
  logic [W-1:0]        c, m;
  logic [CW-1:0]       i, j;

  // One multiplier serves both phases; RED_M reuses it for T0*n0'.
  logic [W-1:0] mx, my, mt, mc, hi, lo;
  always_comb begin
    mx = a_q[int'(j)*W +: W];
    my = b_q[int'(i)*W +: W];
    mt = t[j];
    mc = c;
    if (state == ST_RED_M) begin
      mx = t[0];
      my = p_inv[W-1:0];
      mt = '0;
      mc = '0;
    end else if (state == ST_RED) begin
      mx = m;
      my = p[int'(j)*W +: W];
    end
  end

  word_mac #(.W(W)) u_mac (.x(mx), .y(my), .t(mt), .c(mc), .hi(hi), .lo(lo));

  // Top-word carry fold, shared by MAC_TOP and RED_TOP.
  logic [W:0] top;
  assign top = {1'b0, t[S]} + {1'b0, c};

  // Both candidates of every result are formed unconditionally; only the mux
  // depends on the data, so timing never does.
  logic [N:0]   s_add, tz;
  logic [N-1:0] add_res, sub_res, fin_res;
  assign s_add   = {1'b0, a_q} + {1'b0, b_q};
  assign add_res = (s_add >= {1'b0, p}) ? N'(s_add - {1'b0, p}) : s_add[N-1:0];
  assign sub_res = (a_q < b_q) ? (a_q - b_q + p) : (a_q - b_q);
  // CIOS leaves T < 2p, so only bit 0 of the top word can be set.
  assign tz      = {t[S][0], t[S-1:0]};
  assign fin_res = (tz >= {1'b0, p}) ? N'(tz - {1'b0, p}) : tz[N-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      mul      <= '0;
      done_mul <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      t        <= '0;
      c        <= '0;
      m        <= '0;
      i        <= '0;
      j        <= '0;
    end else if (rst_mul) begin
      // Clearing here guarantees done_mul is low once rst_mul falls again.
      state    <= ST_IDLE;
      done_mul <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          a_q   <= A;
          b_q   <= B;
          op_q  <= op;
          t     <= '0;
          c     <= '0;
          i     <= '0;
          j     <= '0;
          state <= (op == OP_MUL) ? ST_MAC : ST_ADDSUB;
        end
        ST_ADDSUB: begin
          case (op_q)
            OP_ADD:  mul <= add_res;
            OP_SUB:  mul <= sub_res;
            default: mul <= '0;
          endcase
          done_mul <= 1'b1;
          state    <= ST_DONE;
        end
        ST_MAC: begin
          t[j] <= lo;
          c    <= hi;
          j    <= j + 1'b1;
          if (j == LAST) begin
            j     <= '0;
            state <= ST_MAC_TOP;
          end
        end
        ST_MAC_TOP: begin
          t[S]   <= top[W-1:0];
          t[S+1] <= {{(W-1){1'b0}}, top[W]};
          state  <= ST_RED_M;
        end
        ST_RED_M: begin
          m     <= lo;
          c     <= '0;
          state <= ST_RED;
        end
        ST_RED: begin
          // Word 0 becomes zero by construction of m and is dropped.
          if (j != '0) t[j - 1'b1] <= lo;
          c <= hi;
          j <= j + 1'b1;
          if (j == LAST) begin
            j     <= '0;
            state <= ST_RED_TOP;
          end
        end
        ST_RED_TOP: begin
          t[S-1] <= top[W-1:0];
          t[S]   <= t[S+1] + {{(W-1){1'b0}}, top[W]};
          t[S+1] <= '0;
          c      <= '0;
          if (i == LAST) begin
            state <= ST_FINAL;
          end else begin
            i     <= i + 1'b1;
            state <= ST_MAC;
          end
        end
        ST_FINAL: begin
          mul      <= fin_res;
          done_mul <= 1'b1;
          state    <= ST_DONE;
        end
        ST_DONE: state <= ST_DONE;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_arith_unit.sv
`timescale 1ns/1ps
module tb_fp_arith_unit;
  localparam logic [511:0] PT =
    512'h65b48e8f740f89bf_fc8ab0d15e3e4c4a_b42d083aedc88c42_5afbfcc69322c9cd_a7aac6c567f35507_516730cc1f0b4f25_c2721bf457aca835_1b81b90533c6c87b;
  localparam int MUL_LAT = 562;
  localparam int AS_LAT  = 2;

  logic         clk, rst, rst_mul, done_mul;
  logic [511:0] A, B, mul;
  logic [1:0]   op;

  int checks = 0;
  int errors = 0;

  fp_arith_unit dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .op(op),
    .rst_mul(rst_mul), .mul(mul), .done_mul(done_mul)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Radix-2 bit-serial Montgomery reduction: a*b*2^-512 mod p.
  function automatic logic [511:0] mont_ref(input logic [511:0] a, input logic [511:0] b);
    logic [513:0] r;
    r = '0;
    for (int k = 0; k < 512; k++) begin
      if (a[k]) r = r + {2'b0, b};
      if (r[0]) r = r + {2'b0, PT};
      r = r >> 1;
    end
    if (r >= {2'b0, PT}) r = r - {2'b0, PT};
    return r[511:0];
  endfunction

  function automatic logic [511:0] add_ref(input logic [511:0] a, input logic [511:0] b);
    logic [512:0] s;
    s = ({1'b0, a} + {1'b0, b}) % {1'b0, PT};
    return s[511:0];
  endfunction

  function automatic logic [511:0] sub_ref(input logic [511:0] a, input logic [511:0] b);
    logic [512:0] s;
    s = ({1'b0, a} + {1'b0, PT} - {1'b0, b}) % {1'b0, PT};
    return s[511:0];
  endfunction

  function automatic logic [511:0] rnd();
    logic [511:0] r;
    for (int k = 0; k < 16; k++) r[k*32 +: 32] = $urandom;
    return r % PT;
  endfunction

  // Initiator pattern: drop rst_mul with the request, wait for done_mul,
  // take the result, pulse rst_mul for one cycle. Operands are scrambled
  // after the capture cycle to prove they are ignored.
  task automatic run_op(input string tag, input logic [511:0] a, input logic [511:0] b,
                        input logic [1:0] o, output logic [511:0] res, output int lat);
    rst_mul = 1'b0;
    A = a;
    B = b;
    op = o;
    check({tag, " done low at c0"}, 512'(done_mul), 512'(0));
    lat = 0;
    while (done_mul !== 1'b1 && lat < 2000) begin
      tick();
      lat++;
      if (lat == 1) begin
        A = ~a;
        B = ~b;
        op = ~o;
      end
    end
    res = mul;
    rst_mul = 1'b1;
    tick();
  endtask

  task automatic do_check(input string tag, input logic [511:0] a, input logic [511:0] b,
                          input logic [1:0] o, input logic [511:0] exp, input int exp_lat);
    logic [511:0] res;
    int           lat;
    run_op(tag, a, b, o, res, lat);
    check({tag, " result"}, res, exp);
    check({tag, " latency"}, 512'(lat), 512'(exp_lat));
  endtask

  initial begin : stim
    logic [511:0] fp1, prev, ra, rb, ex;
    logic [513:0] acc;
    logic [1:0]   o;
    int           highs, el;

    // Bench-side 2^512 mod p by repeated modular doubling.
    acc = 514'd1;
    for (int k = 0; k < 512; k++) begin
      acc = acc << 1;
      if (acc >= {2'b0, PT}) acc = acc - {2'b0, PT};
    end
    fp1 = acc[511:0];

    rst = 1'b1; rst_mul = 1'b1; A = '0; B = '0; op = 2'b00;
    tick(); tick();
    check("reset mul", mul, '0);
    check("reset done", 512'(done_mul), 512'(0));
    rst = 1'b0;
    tick();

    do_check("add wrap", PT - 512'd1, 512'd2, 2'b01, 512'd1, AS_LAT);
    do_check("add plain", 512'd3, 512'd4, 2'b01, 512'd7, AS_LAT);
    do_check("sub borrow", 512'd1, 512'd2, 2'b10, PT - 512'd1, AS_LAT);
    do_check("sub equal", 512'd5, 512'd5, 2'b10, 512'd0, AS_LAT);
    do_check("reserved op", 512'd9, 512'd7, 2'b11, 512'd0, AS_LAT);

    do_check("mont fp1*fp1", fp1, fp1, 2'b00, fp1, MUL_LAT);
    do_check("mont 1*fp1", 512'd1, fp1, 2'b00, 512'd1, MUL_LAT);
    do_check("mont 0*(p-1)", 512'd0, PT - 512'd1, 2'b00, 512'd0, MUL_LAT);
    do_check("mont (p-1)^2", PT - 512'd1, PT - 512'd1, 2'b00,
             mont_ref(PT - 512'd1, PT - 512'd1), MUL_LAT);
    for (int k = 0; k < 4; k++) begin
      ra = rnd();
      rb = rnd();
      do_check($sformatf("mont rand%0d", k), ra, rb, 2'b00, mont_ref(ra, rb), MUL_LAT);
    end

    // rst_mul held low after completion: result and valid must hold.
    rst_mul = 1'b0; A = 512'd7; B = 512'd8; op = 2'b01;
    tick(); tick();
    A = 512'd100; B = 512'd200; op = 2'b10;
    for (int k = 0; k < 5; k++) tick();
    check("hold done", 512'(done_mul), 512'(1));
    check("hold mul", mul, 512'd15);
    rst_mul = 1'b1;
    tick();
    check("release clears done", 512'(done_mul), 512'(0));

    // Abort a multiply at c0+100.
    prev = mul;
    highs = 0;
    rst_mul = 1'b0; A = rnd(); B = rnd(); op = 2'b00;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (done_mul) highs++;
    end
    rst_mul = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (done_mul) highs++;
    end
    check("abort done never high", 512'(highs), 512'(0));
    check("abort mul unchanged", mul, prev);
    do_check("add after abort", 512'd10, 512'd20, 2'b01, 512'd30, AS_LAT);

    // Chained requests with mixed opcodes.
    for (int k = 0; k < 22; k++) begin
      o  = 2'(k % 4);
      ra = rnd();
      rb = rnd();
      case (o)
        2'b00:   begin ex = mont_ref(ra, rb); el = MUL_LAT; end
        2'b01:   begin ex = add_ref(ra, rb);  el = AS_LAT;  end
        2'b10:   begin ex = sub_ref(ra, rb);  el = AS_LAT;  end
        default: begin ex = '0;               el = AS_LAT;  end
      endcase
      do_check($sformatf("chain%0d op%0d", k, o), ra, rb, o, ex, el);
    end

    // Global reset in the middle of a multiply.
    rst_mul = 1'b0; A = fp1; B = fp1; op = 2'b00;
    for (int k = 0; k < 50; k++) tick();
    rst = 1'b1;
    tick();
    check("rst mid-mul mul", mul, '0);
    check("rst mid-mul done", 512'(done_mul), 512'(0));
    rst = 1'b0; rst_mul = 1'b1;
    tick();
    do_check("add after rst", PT - 512'd3, 512'd5, 2'b01, 512'd2, AS_LAT);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fp_arith_unit.md
# fp_arith_unit

Responder side of the shared field-arithmetic port used by the CSIDH curve-arithmetic controllers (point add/double and similar). Takes operands `A`, `B` and opcode `op` under the `rst_mul`/`done_mul` handshake. Returns a Montgomery product, modular sum or modular difference mod p on `mul`. Latency depends only on `op`, never on operand values (constant time).

## Interface
- `N`, 512: prime bit-width.
- `word_size`, 32: multiplier word width; `N % word_size == 0`; `S = N/word_size` (16 by default).
- `p`, CSIDH-512 prime: field modulus.
- `p_inv`, (-p)^-1 mod 2^N: only bits `[word_size-1:0]` (n0') are used.
- `clk`  in  1  clock; the block uses only this one clock.
- `rst`  in  1  reset, synchronous, active-high.
- `A`  in  N  operand A, required < p.
- `B`  in  N  operand B, required < p.
- `op`  in  2  00 = Montgomery mul, 01 = add, 10 = sub (A−B), 11 = reserved.
- `rst_mul`  in  1  high: abort/idle; low: start and hold the request.
- `mul`  out  N  result, registered.
- `done_mul`  out  1  result valid, registered.

## Operation
- Request: the first cycle with `rst_mul`=0 and state IDLE is c0. `A`, `B` and `op` are captured at the end of c0. Later changes on `A`/`B`/`op` are ignored.
- Add: s = A+B (N+1 bits); result = s−p if s ≥ p, else s.
- Sub: d = A−B; result = d+p on borrow, else d.
- Both candidates are always computed and a mux selects between them.
- Reserved op 11: result 0, same timing as add/sub.
- Mul: word-serial CIOS Montgomery; result = A·B·2^−N mod p, in [0, p).
  - Accumulator T is S+2 words.
  - Per outer index i = 0..S−1:
    - MAC: S cycles, (c, T_j) = T_j + A_j·B_i + c.
    - MAC_TOP: 1 cycle, fold carry into T_S, T_S+1.
    - RED_M: 1 cycle, m = T_0·n0' mod 2^w.
    - RED: S cycles, (c, T_j−1) = T_j + m·p_j + c; the j=0 word is discarded.
    - RED_TOP: 1 cycle, shift the top words down.
  - FINAL: 1 cycle; T−p is always computed and T or T−p is selected.
- States: IDLE, ADDSUB, MAC, MAC_TOP, RED_M, RED, RED_TOP, FINAL, DONE.
  - IDLE→ADDSUB when `op`≠00; IDLE→MAC when `op`=00.
  - ADDSUB→DONE.
  - RED_TOP→MAC while i<S−1, else RED_TOP→FINAL.
  - FINAL→DONE.
  - DONE→IDLE when `rst_mul`=1.
- On entering DONE: `mul` is written and `done_mul`=1. Both hold until `rst_mul`=1.
- `rst_mul`=1 in any state: next state IDLE, `done_mul`←0, no result is written, `mul` keeps its old value.
- `rst`=1 overrides everything: state IDLE, `mul`=0, `done_mul`=0, counters i/j=0, T=0.

## Timing
- Add/sub/reserved: `done_mul` is first high in cycle c0+2.
- Mul: `done_mul` is first high in c0+2+S·(2S+3); 562 cycles for S=16.
- Handshake: the initiator samples `done_mul`=1 with `rst_mul`=0, then drives `rst_mul`=1 for ≥1 cycle.
  - `done_mul` must be 0 in the first cycle after `rst_mul` returns low. Clearing it on the `rst_mul`=1 edge guarantees this.
  - The next request's c0 is the first `rst_mul`=0 cycle after that.
- Back-to-back requests therefore need no idle cycles beyond the initiator's single `rst_mul` pulse.
- `rst_mul` held low after DONE: the unit stays in DONE and does not recompute.

## Structure
- Shared package `csidh_pkg`:
  - constants `P`, `P_INV`, `FP1` (2^N mod p).
  - op encodings `OP_MUL`, `OP_ADD`, `OP_SUB`.
  - state enum.
- Sub-module `word_mac`: combinational {hi, lo} = x·y + t + c over w-bit inputs, 2w-bit output. It is instantiated once and shared by the MAC and RED phases.
- Word selection of A_j, B_i and p_j: indexed part-selects on the captured registers.

## Test plan
- Add wrap: A=p−1, B=2, op=01 → `mul`=1, `done_mul` high at c0+2.
- Sub borrow: A=1, B=2, op=10 → `mul`=p−1; A=5, B=5 → 0.
- Montgomery identity:
  - A=FP1, B=FP1 → FP1.
  - A=1, B=FP1 → 1.
  - A=0, B=p−1 → 0.
  - All at exactly c0+562.
- Constant time: random operand pairs including p−1·p−1 → all mul latencies identical. Results match a reference model of A·B·2^−512 mod p.
- Abort: `rst_mul`=1 at cycle c0+100 of a mul → `done_mul` never rises, `mul` unchanged. The following add request returns the correct result at +2.
- Handshake: emulate the initiator's register pattern over 22 chained ops → `done_mul` is 0 in every cycle immediately after `rst_mul` falls. `rst` mid-mul → `mul`=0, `done_mul`=0 next cycle.
